// File: rtl/nibble_pingpong_pkg.sv
// Shared definitions for the nibble ping-pong buffer and the downstream 2:1 nibble mux.
package nibble_pingpong_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_HALF  = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

  // Occupancy after one edge; push and pop together leave it unchanged.
  function automatic cnt_e cnt_next(cnt_e cur, logic push, logic pop);
    cnt_e nxt;
    nxt = cur;
    unique case ({push, pop})
      2'b10:   nxt = (cur == CNT_EMPTY) ? CNT_HALF : CNT_FULL;
      2'b01:   nxt = (cur == CNT_FULL) ? CNT_HALF : CNT_EMPTY;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/nibble_bank_reg.sv
// WIDTH-bit storage register with write enable; one instance per ping-pong bank.
module nibble_bank_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (we)
      q <= d;
  end

endmodule

// File: rtl/nibble_pingpong_buffer.sv
// Two-entry ping-pong buffer feeding the 2:1 nibble mux; sel always points at the oldest unread bank.
// Optional synchronous flush port enabled by NIBBLE_PINGPONG_FLUSH_EN.
//
// count     | meaning
// ----------+------------------------------------------
// CNT_EMPTY | no unread word, out_valid low
// CNT_HALF  | one unread word at bank[sel]
// CNT_FULL  | both banks unread, in_ready low
module nibble_pingpong_buffer
  import nibble_pingpong_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef NIBBLE_PINGPONG_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] bank_a,
  output logic [WIDTH-1:0] bank_b,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready
);

  cnt_e count;
  logic wr_ptr;
  logic flush_now;
  logic push;
  logic pop;

`ifdef NIBBLE_PINGPONG_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign in_ready  = (count != CNT_FULL) && !rst && !flush_now;
  assign out_valid = (count != CNT_EMPTY);

  // in_ready already excludes flush, so a push during flush is never stored.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !flush_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= CNT_EMPTY;
      wr_ptr <= 1'b0;
      sel    <= 1'b0;
    end else if (flush_now) begin
      count  <= CNT_EMPTY;
      wr_ptr <= 1'b0;
      sel    <= 1'b0;
    end else begin
      count <= cnt_next(count, push, pop);
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        sel <= ~sel;
    end
  end

  nibble_bank_reg #(.WIDTH(WIDTH)) u_bank_a (
    .clk (clk),
    .rst (rst),
    .we  (push && !wr_ptr),
    .d   (in_data),
    .q   (bank_a)
  );

  nibble_bank_reg #(.WIDTH(WIDTH)) u_bank_b (
    .clk (clk),
    .rst (rst),
    .we  (push && wr_ptr),
    .d   (in_data),
    .q   (bank_b)
  );

  // Write pointer runs ahead of the read pointer by exactly the occupancy.
  a_ptr_inv: assert property (@(posedge clk) disable iff (rst)
    (count == CNT_FULL) ? (wr_ptr == sel) : (wr_ptr == (sel ^ count[0])));

  a_cnt_legal: assert property (@(posedge clk) disable iff (rst)
    count inside {CNT_EMPTY, CNT_HALF, CNT_FULL});

endmodule
